melody_sequencer: RTL and testbench

Sequences a stored melody into the monophonic note generator. Fetches packed note/duration entries from an external synchronous score ROM, then drives the generator's 7-bit note index and out_enable for a timed duration. Inserts a short silent gap between notes for articulation. Supports start, stop, looping and end-of-song signalling. Sits between the game-sound control logic and the note generator on the 10 MHz sound clock.

---
 rtl/melody_sequencer.sv | 177 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a packed score ROM and drives the note generator
// with timed notes, rests and a short articulation gap between entries.
module melody_sequencer #(
    parameter int TICK_DIV  = 100000,
    parameter int ADDR_W    = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [6:0]        note,
    output logic              out_enable,
    output logic              busy,
    output logic              song_done
);

    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_CLKS = GAP_TICKS * TICK_DIV;
    localparam int GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = (GAP_CLKS > 0) ? GAP_W'(GAP_CLKS - 1) : '0;
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [6:0]        NOTE_MAX  = 7'd107;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        PLAY,
        GAP
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [6:0]        note_reg, note_next;
    logic              oe_reg, oe_next;
    logic              done_reg, done_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [7:0]        dur_reg, dur_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    // Set when the address wrapped past the top of the ROM; the next LATCH
    // then treats the fetched word as an end marker.
    logic              wrap_reg, wrap_next;
    logic              advance;

    logic       rom_rest;
    logic [6:0] rom_note;
    logic [7:0] rom_dur;

    assign rom_rest = rom_data[15];
    assign rom_note = rom_data[14:8];
    assign rom_dur  = rom_data[7:0];

    assign rom_addr   = addr_reg;
    assign note       = note_reg;
    assign out_enable = oe_reg;
    assign song_done  = done_reg;
    assign busy       = (state_reg != IDLE);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            note_reg  <= '0;
            oe_reg    <= 1'b0;
            done_reg  <= 1'b0;
            tick_reg  <= '0;
            dur_reg   <= '0;
            gap_reg   <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            note_reg  <= note_next;
            oe_reg    <= oe_next;
            done_reg  <= done_next;
            tick_reg  <= tick_next;
            dur_reg   <= dur_next;
            gap_reg   <= gap_next;
            wrap_reg  <= wrap_next;
        end
    end

    // Next-state and output logic; stop overrides everything else.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        note_next  = note_reg;
        oe_next    = oe_reg;
        done_next  = 1'b0;
        tick_next  = tick_reg;
        dur_next   = dur_reg;
        gap_next   = gap_reg;
        wrap_next  = wrap_reg;
        advance    = 1'b0;

        if (stop) begin
            state_next = IDLE;
            addr_next  = '0;
            oe_next    = 1'b0;
            wrap_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_next  = '0;
                        wrap_next  = 1'b0;
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    state_next = LATCH;
                end
                LATCH: begin
                    if (wrap_reg || (rom_dur == 8'd0)) begin
                        // An end marker at address 0 never loops, so an
                        // empty song cannot spin forever.
                        wrap_next = 1'b0;
                        if (loop_en && (wrap_reg || (addr_reg != '0))) begin
                            addr_next  = '0;
                            state_next = FETCH;
                        end else begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        note_next  = rom_note;
                        dur_next   = rom_dur;
                        tick_next  = '0;
                        oe_next    = !rom_rest && (rom_note <= NOTE_MAX);
                        state_next = PLAY;
                    end
                end
                PLAY: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next = '0;
                        dur_next  = dur_reg - 8'd1;
                        if (dur_reg == 8'd1) begin
                            oe_next = 1'b0;
                            if (GAP_TICKS > 0) begin
                                gap_next   = '0;
                                state_next = GAP;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        advance = 1'b1;
                    end else begin
                        gap_next = gap_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            if (advance) begin
                addr_next  = addr_reg + 1'b1;
                wrap_next  = (addr_reg == ADDR_MAX);
                state_next = FETCH;
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed scenarios plus a
// randomized run, all compared every cycle against an entry/offset model.
module tb_melody_sequencer;

    localparam int T = 4;   // clocks per tick
    localparam int G = 1;   // gap ticks

    logic        clk = 1'b0;
    logic        reset, start, stop, loop_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [6:0]  note;
    logic        out_enable, busy, song_done;

    logic [15:0] rom [256];

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    melody_sequencer #(.TICK_DIV(T), .ADDR_W(8), .GAP_TICKS(G)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
        .out_enable(out_enable), .busy(busy), .song_done(song_done)
    );

    always #5 clk = ~clk;

    // Synchronous score ROM: data valid one clock after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Reference model: position in the song is (entry address, clock offset k
    // within the entry). k=0 fetch, k=1 decode, then duration*T sounding
    // clocks, then G*T gap clocks.
    bit          m_busy, m_oe, m_done, m_wrap;
    logic [7:0]  m_addr;
    logic [6:0]  m_note;
    logic [15:0] m_w;
    int          m_k, m_dur;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_busy = 0; m_addr = 0; m_note = 0; m_oe = 0; m_wrap = 0; m_k = 0;
        end else if (stop) begin
            m_busy = 0; m_addr = 0; m_oe = 0; m_wrap = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_addr = 0; m_k = 0; m_wrap = 0;
            end
        end else if (m_k == 1) begin
            m_w = rom[m_addr];
            if (m_wrap || m_w[7:0] == 8'd0) begin
                if (loop_en && (m_wrap || m_addr != 0)) begin
                    m_addr = 0; m_k = 0; m_wrap = 0;
                end else begin
                    m_busy = 0; m_done = 1; m_wrap = 0;
                end
            end else begin
                m_note = m_w[14:8];
                m_dur  = int'(m_w[7:0]);
                m_oe   = !m_w[15] && (m_w[14:8] <= 7'd107);
                m_k    = 2;
            end
        end else begin
            m_k++;
            if (m_k == 2 + m_dur * T) m_oe = 0;
            if (m_k == 2 + (m_dur + G) * T) begin
                m_wrap = (m_addr == 8'hFF);
                m_addr = m_addr + 8'd1;
                m_k    = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rom_addr",   32'(rom_addr),   32'(m_addr));
            chk("note",       32'(note),       32'(m_note));
            chk("out_enable", 32'(out_enable), 32'(m_oe));
            chk("busy",       32'(busy),       32'(m_busy));
            chk("song_done",  32'(song_done),  32'(m_done));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Count outputs until the sequencer returns to idle (bounded).
    task automatic wait_idle(input string tag, input int budget,
                             output int oe_c, output int busy_c, output int done_c);
        int n;
        oe_c = 0; busy_c = 0; done_c = 0; n = 0;
        while (1) begin
            if (busy) busy_c++;
            if (out_enable) oe_c++;
            if (song_done) done_c++;
            if (!busy) break;
            if (n >= budget) begin
                compared++; mismatched++;
                $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
                break;
            end
            n++;
            @(negedge clk);
        end
        $display("song %s: oe_clocks=%0d busy_clocks=%0d done_pulses=%0d", tag, oe_c, busy_c, done_c);
    endtask

    task automatic run_song(input string tag, input int budget,
                            output int oe_c, output int busy_c, output int done_c);
        pulse_start();
        wait_idle(tag, budget, oe_c, busy_c, done_c);
    endtask

    task automatic check_idle_literals(input string tag);
        chk({tag, "_oe"},   32'(out_enable), 0);
        chk({tag, "_busy"}, 32'(busy),       0);
        chk({tag, "_addr"}, 32'(rom_addr),   0);
        chk({tag, "_done"}, 32'(song_done),  0);
    endtask

    initial begin
        int oe_c, busy_c, done_c;
        int saw1, dones;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_idle_literals("reset");
        chk("reset_note", 32'(note), 0);
        reset = 1'b0;

        // 1: single A4 for 8 ticks then end
        rom[0] = 16'h3908; rom[1] = 16'h0000;
        run_song("t1", 200, oe_c, busy_c, done_c);
        chk("t1_oe_clocks", oe_c, 32);
        chk("t1_busy_clocks", busy_c, 40);
        chk("t1_done", done_c, 1);
        chk("t1_note", 32'(note), 57);

        // 2: rest entry then note 48
        clear_rom();
        rom[0] = 16'h8003; rom[1] = 16'h3002; rom[2] = 16'h0000;
        run_song("t2", 200, oe_c, busy_c, done_c);
        chk("t2_oe_clocks", oe_c, 8);
        chk("t2_busy_clocks", busy_c, 34);
        chk("t2_done", done_c, 1);

        // 3: looping, then drop loop_en
        clear_rom();
        rom[0] = 16'h3C01; rom[1] = 16'h0000;
        loop_en = 1'b1;
        pulse_start();
        saw1 = 0; dones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rom_addr == 8'd1) saw1 = 1;
            if (song_done) dones++;
        end
        chk("t3_saw_addr1", saw1, 1);
        chk("t3_no_done", dones, 0);
        chk("t3_busy", 32'(busy), 1);
        loop_en = 1'b0;
        wait_idle("t3", 100, oe_c, busy_c, done_c);
        chk("t3_done", done_c, 1);

        // 4: stop mid-PLAY together with start
        clear_rom();
        rom[0] = 16'h3908; rom[1] = 16'h0000;
        pulse_start();
        repeat (10) @(negedge clk);
        chk("t4_playing", 32'(out_enable), 1);
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        check_idle_literals("t4");
        @(negedge clk);
        chk("t4_still_idle", 32'(busy), 0);
        stop = 1'b0; start = 1'b0;

        // 5: empty song with loop_en, and an out-of-range note
        clear_rom();
        loop_en = 1'b1;
        run_song("t5a", 50, oe_c, busy_c, done_c);
        chk("t5a_busy_clocks", busy_c, 2);
        chk("t5a_done", done_c, 1);
        loop_en = 1'b0;
        rom[0] = 16'h7F02; rom[1] = 16'h0000;
        run_song("t5b", 100, oe_c, busy_c, done_c);
        chk("t5b_oe_clocks", oe_c, 0);
        chk("t5b_busy_clocks", busy_c, 16);
        chk("t5b_note", 32'(note), 127);

        // 6: reset during PLAY and during GAP, then replay
        clear_rom();
        rom[0] = 16'h3908; rom[1] = 16'h0000;
        pulse_start();
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_literals("t6_play");
        chk("t6_play_note", 32'(note), 0);
        reset = 1'b0;
        pulse_start();
        repeat (35) @(negedge clk);
        chk("t6_in_gap", 32'(out_enable), 0);
        chk("t6_in_gap_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_literals("t6_gap");
        reset = 1'b0;
        run_song("t6_replay", 200, oe_c, busy_c, done_c);
        chk("t6_oe_clocks", oe_c, 32);
        chk("t6_busy_clocks", busy_c, 40);
        chk("t6_done", done_c, 1);

        // Address wrap acts as an end marker
        for (int i = 0; i < 256; i++) rom[i] = 16'h0101;
        run_song("wrap", 3000, oe_c, busy_c, done_c);
        chk("wrap_busy_clocks", busy_c, 2562);
        chk("wrap_oe_clocks", oe_c, 1024);
        chk("wrap_done", done_c, 1);

        // Randomized songs and control activity
        for (int it = 0; it < 40; it++) begin
            int n, cyc;
            clear_rom();
            n = int'($urandom_range(1, 4));
            for (int a = 0; a < n; a++) begin
                logic [15:0] w;
                w[15]   = ($urandom_range(0, 3) == 0);
                w[14:8] = 7'($urandom_range(0, 127));
                w[7:0]  = 8'($urandom_range(1, 3));
                rom[a]  = w;
            end
            loop_en = 1'($urandom_range(0, 1));
            pulse_start();
            cyc = int'($urandom_range(20, 300));
            for (int c = 0; c < cyc; c++) begin
                @(negedge clk);
                start = ($urandom_range(0, 19) == 0);
                stop  = ($urandom_range(0, 99) == 0);
                reset = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 29) == 0) loop_en = ~loop_en;
            end
            @(negedge clk);
            start = 1'b0; reset = 1'b0; stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            $display("random run %0d: entries=%0d cycles=%0d", it, n, cyc);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
